// File: rtl/load_store_unit.sv
// Load/store unit: turns one MEM-stage load/store into one or two word-aligned,
// byte-strobed accesses on a req/ack memory port and returns extended load data.
module load_store_unit #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_1000,
    parameter logic [31:0] ADDR_SIZE = 32'h0000_1000,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t      state, state_nx;
    logic        we_q, err_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q, lo_q, rdata_q;
    logic [CW-1:0] cnt;

    logic        in_enc_ok, in_range_ok;
    logic [32:0] in_last, win_last;
    logic [3:0]  size_mask;
    logic [7:0]  lane_mask;
    logic [31:0] data_sized, ld_word, ld_ext;
    logic [63:0] wide_wdata, rd_buf;
    logic        crosses, acc_fin, tmo;

    function automatic logic [1:0] len_m1(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    // Request decode on the live inputs, used only in IDLE.
    assign in_enc_ok   = !(req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11) &&
                         !(req_we && req_funct3[2]);
    assign in_last     = {1'b0, req_addr} + {31'b0, len_m1(req_funct3)};
    assign win_last    = {1'b0, ADDR_BASE} + {1'b0, ADDR_SIZE} - 33'd1;
    assign in_range_ok = (req_addr >= ADDR_BASE) && (in_last <= win_last);

    always_comb begin
        case (len_m1(f3_q))
            2'd0:    size_mask = 4'b0001;
            2'd1:    size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    end

    // Lanes [3:0] belong to the first word, lanes [7:4] spill into the next one.
    assign lane_mask  = {4'b0000, size_mask} << addr_q[1:0];
    assign crosses    = |lane_mask[7:4];
    assign data_sized = req_wdata_mask(wdata_q, size_mask);
    assign wide_wdata = {32'b0, data_sized} << {addr_q[1:0], 3'b000};

    function automatic logic [31:0] req_wdata_mask(input logic [31:0] d, input logic [3:0] m);
        return d & {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    assign rd_buf  = (state == ACC1) ? {mem_rdata, lo_q} : {32'b0, mem_rdata};
    assign ld_word = 32'(rd_buf >> {addr_q[1:0], 3'b000});

    always_comb begin
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_word[7]}}, ld_word[7:0]};
            3'b001:  ld_ext = {{16{ld_word[15]}}, ld_word[15:0]};
            3'b100:  ld_ext = {24'b0, ld_word[7:0]};
            3'b101:  ld_ext = {16'b0, ld_word[15:0]};
            default: ld_ext = ld_word;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        resp_valid = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        acc_fin   = 1'b0;
        tmo       = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nx = (in_enc_ok && in_range_ok) ? ACC0 : RESP;
            end
            ACC0: begin
                mem_req  = 1'b1;
                mem_we   = we_q;
                mem_addr = {addr_q[31:2], 2'b00};
                if (we_q) begin
                    mem_wdata = wide_wdata[31:0];
                    mem_wstrb = lane_mask[3:0];
                end
                // An ack in the final counted cycle takes priority over the timeout.
                if (mem_ack) begin
                    state_nx = crosses ? ACC1 : RESP;
                    acc_fin  = !crosses;
                end else if (cnt == CNT_LAST) begin
                    tmo      = 1'b1;
                    state_nx = RESP;
                end
            end
            ACC1: begin
                mem_req  = 1'b1;
                mem_we   = we_q;
                mem_addr = {addr_q[31:2] + 30'd1, 2'b00};
                if (we_q) begin
                    mem_wdata = wide_wdata[63:32];
                    mem_wstrb = lane_mask[7:4];
                end
                if (mem_ack) begin
                    state_nx = RESP;
                    acc_fin  = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    tmo      = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            lo_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                we_q    <= req_we;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                rdata_q <= '0;
                err_q   <= !(in_enc_ok && in_range_ok);
            end
            if (state == ACC0 && mem_ack && crosses) lo_q <= mem_rdata;
            if (acc_fin) rdata_q <= we_q ? '0 : ld_ext;
            if (tmo) begin
                err_q   <= 1'b1;
                rdata_q <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    cnt <= '0;
        else if (mem_req && !mem_ack) cnt <= cnt + 1'b1;
        else                        cnt <= '0;
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule
